// File: rtl/frontend_response_router.sv
// Frontend response router: in-order return FIFO from backend to per-core ports.
// Define FRONTEND_WRITE_ACK_EN to deliver write completions (data forced to 0).
`timescale 1ns/1ps
module frontend_response_router #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter int NUM_CORES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       be_resp_valid,
  output logic                       be_resp_ready,
  input  logic                       be_resp_op,
  input  logic [4:0]                 be_resp_req_id,
  input  logic [1:0]                 be_resp_core_num,
  input  logic [DATA_W-1:0]          be_resp_data,
  output logic [NUM_CORES-1:0]       core_resp_valid,
  input  logic [NUM_CORES-1:0]       core_resp_ready,
  output logic                       core_resp_op,
  output logic [4:0]                 core_resp_req_id,
  output logic [DATA_W-1:0]          core_resp_data,
  output logic [15:0]                resp_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic              mem_op   [DEPTH];
  logic [4:0]        mem_id   [DEPTH];
  logic [1:0]        mem_core [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  logic              out_valid;
  logic [1:0]        out_core;

  logic              keep;
  logic [DATA_W-1:0] in_data;
  logic              accept;
  logic              sel_ready;
  logic              drop;
  logic              fire;
  logic              deliver;
  logic              load;
  logic              fifo_nz;
  logic              pop;
  logic              bypass;
  logic              push;

  // Readiness depends only on the level register.
  assign be_resp_ready = (level != LW'(DEPTH));
  assign fifo_level    = level;
  assign fifo_nz       = (level != '0);

`ifdef FRONTEND_WRITE_ACK_EN
  // Writes travel like reads but carry no data.
  always_comb begin
    keep    = 1'b1;
    in_data = be_resp_op ? be_resp_data : '0;
  end
`else
  // Writes are accepted and silently discarded at the input.
  always_comb begin
    keep    = be_resp_op;
    in_data = be_resp_data;
  end
`endif

  assign accept = be_resp_valid & be_resp_ready & keep;

  // Pick the destination's ready; unknown destinations are dropped.
  always_comb begin
    sel_ready = 1'b0;
    drop      = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (out_core == 2'(i)) begin
        sel_ready = core_resp_ready[i];
        drop      = 1'b0;
      end
    end
  end

  assign fire    = out_valid & (drop | sel_ready);
  assign deliver = out_valid & ~drop & sel_ready;
  assign load    = ~out_valid | fire;
  assign pop     = load & fifo_nz;
  assign bypass  = load & ~fifo_nz & accept;
  assign push    = accept & ~bypass;

  // One-hot valid toward the destination core only.
  always_comb begin
    core_resp_valid = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_resp_valid[i] = out_valid & ~drop & (out_core == 2'(i));
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]   <= be_resp_op;
      mem_id[wr_ptr]   <= be_resp_req_id;
      mem_core[wr_ptr] <= be_resp_core_num;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally; level separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Output register: FIFO head first, else bypass the input, else go idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_core         <= '0;
      core_resp_op     <= 1'b0;
      core_resp_req_id <= '0;
      core_resp_data   <= '0;
    end else if (load) begin
      if (fifo_nz) begin
        out_valid        <= 1'b1;
        out_core         <= mem_core[rd_ptr];
        core_resp_op     <= mem_op[rd_ptr];
        core_resp_req_id <= mem_id[rd_ptr];
        core_resp_data   <= mem_data[rd_ptr];
      end else if (accept) begin
        out_valid        <= 1'b1;
        out_core         <= be_resp_core_num;
        core_resp_op     <= be_resp_op;
        core_resp_req_id <= be_resp_req_id;
        core_resp_data   <= in_data;
      end else begin
        out_valid        <= 1'b0;
      end
    end
  end

  // Count responses actually handed to a core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_count <= '0;
    end else if (deliver) begin
      resp_count <= resp_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_frontend_response_router.sv
// Scoreboard bench for frontend_response_router.
// Honours FRONTEND_WRITE_ACK_EN the same way as the design.
`timescale 1ns/1ps
module tb_frontend_response_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        be_resp_valid = 1'b0;
  logic        be_resp_ready;
  logic        be_resp_op = 1'b0;
  logic [4:0]  be_resp_req_id = '0;
  logic [1:0]  be_resp_core_num = '0;
  logic [63:0] be_resp_data = '0;
  logic [3:0]  core_resp_valid;
  logic [3:0]  core_resp_ready = 4'hF;
  logic        core_resp_op;
  logic [4:0]  core_resp_req_id;
  logic [63:0] core_resp_data;
  logic [15:0] resp_count;
  logic [3:0]  fifo_level;

  frontend_response_router #(.DATA_W(64), .DEPTH(8), .NUM_CORES(4)) dut (
    .clk(clk), .rst(rst),
    .be_resp_valid(be_resp_valid), .be_resp_ready(be_resp_ready),
    .be_resp_op(be_resp_op), .be_resp_req_id(be_resp_req_id),
    .be_resp_core_num(be_resp_core_num), .be_resp_data(be_resp_data),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_op(core_resp_op), .core_resp_req_id(core_resp_req_id),
    .core_resp_data(core_resp_data), .resp_count(resp_count),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [4:0]  id;
    logic [1:0]  core;
    logic [63:0] data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        h;
  logic [15:0] exp_cnt = '0;
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;
  logic [3:0]  ready_fixed = 4'hF;

`ifdef FRONTEND_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endfunction

  // Core ready pattern, applied shortly after each falling edge.
  always begin
    @(negedge clk);
    #1;
    core_resp_ready = rand_ready ? 4'($urandom) : ready_fixed;
  end

  // Monitor: one tick before each rising edge, compare against the queue head.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      chk("resp_count", 64'(resp_count), 64'(exp_cnt));
      if (core_resp_valid != 4'b0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got %b expected none", core_resp_valid);
        end else begin
          h = sbq[0];
          chk("valid_onehot", 64'(core_resp_valid), 64'(4'b1 << h.core));
          if ((core_resp_valid & core_resp_ready) != 4'b0) begin
            chk("resp_op", 64'(core_resp_op), 64'(h.op));
            chk("resp_id", 64'(core_resp_req_id), 64'(h.id));
            chk("resp_data", core_resp_data, h.data);
            void'(sbq.pop_front());
            exp_cnt = exp_cnt + 16'd1;
          end
        end
      end
    end
  end

  // Present one completion from a falling edge until accepted; ends on a falling edge.
  task automatic send(input logic op, input logic [4:0] id,
                      input logic [1:0] core, input logic [63:0] d);
    int n = 0;
    exp_t e;
    be_resp_valid    = 1'b1;
    be_resp_op       = op;
    be_resp_req_id   = id;
    be_resp_core_num = core;
    be_resp_data     = d;
    forever begin
      #4;
      if (be_resp_ready) begin
        if (op || ACK) begin
          e.op   = op;
          e.id   = id;
          e.core = core;
          e.data = op ? d : 64'h0;
          sbq.push_back(e);
        end
        break;
      end
      n++;
      if (n > 500) begin
        fail_now("send_accept");
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    be_resp_valid = 1'b0;
  endtask

  // Wait until the scoreboard is empty; ends on a falling edge.
  task automatic wait_drain(input int bound, output int cyc);
    cyc = 0;
    while (sbq.size() != 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > bound) begin
        fail_now("drain");
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    sbq.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [15:0] c0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(core_resp_valid), 64'h0);
    chk("rst_level", 64'(fifo_level), 64'h0);
    chk("rst_count", 64'(resp_count), 64'h0);
    chk("rst_id", 64'(core_resp_req_id), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(be_resp_ready), 64'h1);

    // Single read bypasses straight to core 2.
    send(1'b1, 5'd3, 2'd2, 64'hA5A5);
    #1;
    chk("t1_valid", 64'(core_resp_valid), 64'h4);
    chk("t1_id", 64'(core_resp_req_id), 64'h3);
    @(negedge clk);
    #1;
    chk("t1_count", 64'(resp_count), 64'h1);
    @(negedge clk);

    // Fill to full with all cores stalled, then release.
    ready_fixed = 4'h0;
    for (int i = 0; i < 8; i++)
      send(1'b1, 5'(10 + i), 2'($urandom), {$urandom, $urandom});
    #1;
    chk("t2_level7", 64'(fifo_level), 64'h7);
    chk("t2_ready7", 64'(be_resp_ready), 64'h1);
    @(negedge clk);
    send(1'b1, 5'd18, 2'd1, 64'h1234);
    #1;
    chk("t2_level8", 64'(fifo_level), 64'h8);
    chk("t2_full", 64'(be_resp_ready), 64'h0);
    @(negedge clk);
    ready_fixed = 4'hF;
    wait_drain(40, cyc);
    chk("t2_drain_cycles", 64'(cyc), 64'd9);

    // Stalled head for core 0 blocks core 1.
    ready_fixed = 4'b1110;
    send(1'b1, 5'd1, 2'd0, 64'h11);
    send(1'b1, 5'd2, 2'd1, 64'h22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t3_hol", 64'(core_resp_valid), 64'h1);
    end
    @(negedge clk);
    ready_fixed = 4'hF;
    wait_drain(20, cyc);

    // Write completion.
    c0 = exp_cnt;
    send(1'b0, 5'd9, 2'd1, 64'hDEAD);
    #1;
    chk("t4_valid", 64'(core_resp_valid), ACK ? 64'h2 : 64'h0);
    if (ACK) begin
      chk("t4_op", 64'(core_resp_op), 64'h0);
      chk("t4_data", core_resp_data, 64'h0);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t4_count", 64'(resp_count), ACK ? 64'(c0 + 16'd1) : 64'(c0));
    @(negedge clk);

    // Asynchronous reset with five entries buffered.
    ready_fixed = 4'h0;
    for (int i = 0; i < 6; i++)
      send(1'b1, 5'(20 + i), 2'(i), 64'(i));
    #1;
    chk("t6_level5", 64'(fifo_level), 64'h5);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(core_resp_valid), 64'h0);
    chk("t6_op", 64'(core_resp_op), 64'h0);
    chk("t6_id", 64'(core_resp_req_id), 64'h0);
    chk("t6_data", core_resp_data, 64'h0);
    chk("t6_count", 64'(resp_count), 64'h0);
    chk("t6_level", 64'(fifo_level), 64'h0);
    sbq.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    ready_fixed = 4'hF;
    #1;
    chk("t6_ready", 64'(be_resp_ready), 64'h1);
    @(negedge clk);

    // Random traffic with random core backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(1'($urandom), 5'($urandom), 2'($urandom), {$urandom, $urandom});
    end
    rand_ready = 1'b0;
    ready_fixed = 4'hF;
    wait_drain(200, cyc);
    #1;
    chk("rand_level", 64'(fifo_level), 64'h0);
    @(negedge clk);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 65535; i++)
      send(1'b1, 5'($urandom), 2'($urandom), 64'(i));
    wait_drain(50, cyc);
    #1;
    chk("t5_ffff", 64'(resp_count), 64'hFFFF);
    @(negedge clk);
    send(1'b1, 5'd7, 2'd3, 64'h77);
    wait_drain(20, cyc);
    #1;
    chk("t5_wrap", 64'(resp_count), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
